operand_select_reg: RTL and testbench
=====================================

Name: operand_select_reg

Overview:
- Parametrised, registered successor to the two-source operand mux that feeds the signed subtracter.
- Selects between a narrow operand A (WA bits, zero- or sign-extended to WB) and a wide operand B (WB bits).
- Four select modes: fixed A, fixed B, alternate, hold-last.
- Output is registered behind a valid/ready handshake, and a transfer counter tracks completed outputs, so the block can sit between operand sources and the subtracter pipeline.

Parameters:
- WA, 4, width of operand A; legal range 1..WB.
- WB, 6, width of operand B and of Mux_Out.
- CNT_W, 8, width of transfer counter xfer_count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- in_valid  input  1  source presents A/B/mode/ext_signed this cycle.
- in_ready  output  1  block accepts input this cycle.
- A  input  WA  narrow operand.
- B  input  WB  wide operand.
- mode  input  2  00 = A, 01 = B, 10 = alternate, 11 = hold-last.
- ext_signed  input  1  1 = sign-extend A, 0 = zero-extend A.
- out_valid  output  1  Mux_Out holds valid data.
- out_ready  input  1  consumer accepts Mux_Out this cycle.
- Mux_Out  output  WB  selected, extended operand.
- out_src  output  1  source of current Mux_Out: 0 = A, 1 = B.
- xfer_count  output  CNT_W  number of completed output handshakes, modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, Reset=1 at a rising clk edge):
  - out_valid=0, Mux_Out=0, out_src=0, xfer_count=0.
  - Alternate flag alt_next=0 (A); hold register last_src=0 (A).
  - Any held output is discarded.
  - in_ready=1 in the cycle after reset.
- Handshake:
  - in_ready = ~out_valid | out_ready (combinational; full throughput, no bubbles).
  - Accept = in_valid & in_ready.
  - Output handshake = out_valid & out_ready.
  - Inputs A/B/mode/ext_signed are sampled only on accept; inputs with in_valid=0 or in_ready=0 are ignored.
- Latency: one cycle. Data accepted at edge N appears on Mux_Out with out_valid=1 after edge N.
- Output register update:
  - On accept: Mux_Out, out_src and out_valid=1 are loaded.
  - Else on output handshake: out_valid=0; Mux_Out and out_src keep their last value.
  - Else: all hold. Mux_Out is stable while out_valid=1 and out_ready=0.
- Source select, evaluated on accept only:
  - mode 00 -> src=A.
  - mode 01 -> src=B.
  - mode 10 -> src=alt_next; alt_next toggles after the accept.
  - mode 11 -> src=last_src.
  - last_src <= src on every accept.
  - alt_next changes only on a mode-10 accept; it keeps its value across non-alternate accepts.
- Extension when src=A:
  - Upper WB-WA bits = A[WA-1] if ext_signed=1, else 0.
  - If WA==WB, no extension.
  - src=B passes B unchanged.
- Counter:
  - xfer_count increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
  - Accept and output handshake in the same cycle: counter increments; register loads new data; out_valid stays 1.
- Mid-operation changes:
  - A mode change takes effect at the next accept.
  - Reset asserted with a pending output: output is dropped and not counted.
- Elaboration: WA>WB or WA<1 is an elaboration error.

Decomposition:
- Shared package: mode constants MODE_A=2'b00, MODE_B=2'b01, MODE_ALT=2'b10, MODE_HOLD=2'b11; source constants SRC_A=0, SRC_B=1.
- One natural sub-module, operand_extend: combinational, parameters WA/WB, inputs A and ext_signed, output A extended to WB bits. Reusable by the subtracter datapath.
- Select logic, output register and counter stay in the top module.

Test Plan:
- Reset: hold Reset=1 for 2 cycles with in_valid=1 -> out_valid=0, Mux_Out=0, xfer_count=0, out_src=0. Cycle after release: in_ready=1.
- Extension: mode=00, A=4'b1010, out_ready=1.
  - ext_signed=0 -> Mux_Out=6'b001010, out_src=0, one cycle after accept.
  - ext_signed=1 -> Mux_Out=6'b111010.
  - A=4'b0111 with ext_signed=1 -> 6'b000111.
- Mode B and hold: mode=01, B=6'b101101 -> Mux_Out=6'b101101, out_src=1. Then mode=11, B=6'b000011 -> Mux_Out=6'b000011, out_src=1.
- Alternate: mode=10, 4 back-to-back accepts with out_ready=1, A=4'b0001, B=6'b100000 -> Mux_Out sequence 000001, 100000, 000001, 100000 with out_src 0,1,0,1; xfer_count=4; in_ready never deasserts.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with in_valid=1 and new A -> in_ready=0, Mux_Out unchanged, alt_next not toggled, xfer_count unchanged. On out_ready=1, the same-cycle accept loads new data and count+1.
- Wrap and reset: CNT_W=2, 5 transfers -> xfer_count 1,2,3,0,1. Then assert Reset while out_valid=1, out_ready=0 -> next cycle out_valid=0, xfer_count=0, and the next mode-10 accept selects A.

Source files
------------

// File: rtl/operand_select_reg_pkg.sv
// operand_select_reg_pkg: shared select-mode and source encodings for the operand selector
package operand_select_reg_pkg;
    localparam logic [1:0] MODE_A    = 2'b00;
    localparam logic [1:0] MODE_B    = 2'b01;
    localparam logic [1:0] MODE_ALT  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;
endpackage

// File: rtl/operand_select_reg_extend.sv
// operand_extend: zero- or sign-extends a WA-bit operand to WB bits (A in, ext_signed in, a_ext out)
module operand_extend #(
    parameter int WA = 4,
    parameter int WB = 6
) (
    input  logic [WA-1:0] A,
    input  logic          ext_signed,
    output logic [WB-1:0] a_ext
);
    if (WA == WB) begin : g_same
        assign a_ext = A;
    end else begin : g_ext
        assign a_ext = {{(WB-WA){ext_signed & A[WA-1]}}, A};
    end
endmodule

// File: rtl/operand_select_reg.sv
// operand_select_reg: registered A/B operand selector with valid/ready handshake and transfer counter
module operand_select_reg
    import operand_select_reg_pkg::*;
#(
    parameter int WA    = 4,
    parameter int WB    = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WA-1:0]    A,
    input  logic [WB-1:0]    B,
    input  logic [1:0]       mode,
    input  logic             ext_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WB-1:0]    Mux_Out,
    output logic             out_src,
    output logic [CNT_W-1:0] xfer_count
);
    if (WA < 1 || WA > WB) begin : g_bad_width
        $error("operand_select_reg: WA must be in 1..WB");
    end
    logic [WB-1:0] a_ext, mux_q, mux_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic valid_q, valid_d, src_q, src_d, alt_q, alt_d, accept, xfer, sel;
    operand_extend #(.WA(WA), .WB(WB)) u_ext (
        .A(A),
        .ext_signed(ext_signed),
        .a_ext(a_ext)
    );
    assign in_ready = ~valid_q | out_ready;
    assign accept = in_valid & in_ready;
    assign xfer = valid_q & out_ready;
    always_comb begin
        sel = mode == MODE_A ? SRC_A : mode == MODE_B ? SRC_B : mode == MODE_ALT ? alt_q : src_q;
        mux_d = accept ? (sel == SRC_B ? B : a_ext) : mux_q;
        src_d = accept ? sel : src_q;
        valid_d = accept | (valid_q & ~out_ready);
        alt_d = (accept && mode == MODE_ALT) ? ~alt_q : alt_q;
        cnt_d = xfer ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (Reset) begin
            mux_q   <= '0;
            src_q   <= SRC_A;
            valid_q <= 1'b0;
            alt_q   <= SRC_A;
            cnt_q   <= '0;
        end else begin
            mux_q   <= mux_d;
            src_q   <= src_d;
            valid_q <= valid_d;
            alt_q   <= alt_d;
            cnt_q   <= cnt_d;
        end
    end
    assign out_valid = valid_q;
    assign Mux_Out = mux_q;
    assign out_src = src_q;
    assign xfer_count = cnt_q;
endmodule

// File: tb/tb_operand_select_reg.sv
// tb_operand_select_reg: table vectors plus scoreboard model checking operand_select_reg
module tb_operand_select_reg;
    import operand_select_reg_pkg::*;
    logic clk = 1'b0, Reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0, ext_signed = 1'b0;
    logic [3:0] A = '0;
    logic [5:0] B = '0;
    logic [1:0] mode = MODE_A;
    logic in_ready, out_valid, out_src, in_ready2, out_valid2, out_src2;
    logic [5:0] Mux_Out, Mux_Out2;
    logic [7:0] xfer_count;
    logic [1:0] xfer_count2;
    operand_select_reg dut (
        .clk(clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .mode(mode), .ext_signed(ext_signed), .out_valid(out_valid), .out_ready(out_ready),
        .Mux_Out(Mux_Out), .out_src(out_src), .xfer_count(xfer_count)
    );
    operand_select_reg #(.CNT_W(2)) dut2 (
        .clk(clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready2), .A(A), .B(B),
        .mode(mode), .ext_signed(ext_signed), .out_valid(out_valid2), .out_ready(out_ready),
        .Mux_Out(Mux_Out2), .out_src(out_src2), .xfer_count(xfer_count2)
    );
    always #5 clk = ~clk;
    typedef struct {logic [5:0] d; logic s;} exp_t;
    typedef struct {logic [1:0] mode; logic [3:0] a; logic [5:0] b; logic ext; logic [5:0] d; logic s;} vec_t;
    exp_t sbq[$];
    vec_t vt[9];
    int wexp[6] = '{0, 1, 2, 3, 0, 1};
    logic m_valid = 1'b0, m_alt = 1'b0, m_last = 1'b0;
    int m_cnt = 0;
    int compared = 0, mismatched = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic cyc();
        logic acc, hs, s, rdy, rst;
        exp_t e;
        #1;
        rst = Reset;
        rdy = ~m_valid | out_ready;
        if (!rst) begin
            chk("in_ready", in_ready, rdy);
            chk("in_ready_w2", in_ready2, rdy);
        end
        acc = in_valid & rdy & ~rst;
        hs = m_valid & out_ready & ~rst;
        if (hs) begin
            void'(sbq.pop_front());
            m_cnt++;
        end
        if (acc) begin
            s = mode == MODE_A ? SRC_A : mode == MODE_B ? SRC_B : mode == MODE_ALT ? m_alt : m_last;
            e.s = s;
            e.d = s ? B : (ext_signed ? {{2{A[3]}}, A} : {2'b00, A});
            sbq.push_back(e);
            if (mode == MODE_ALT) m_alt = ~m_alt;
            m_last = s;
        end
        m_valid = acc | (m_valid & ~hs);
        if (rst) begin
            m_valid = 1'b0;
            m_alt = 1'b0;
            m_last = 1'b0;
            m_cnt = 0;
            sbq.delete();
        end
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", out_valid, m_valid);
        chk("out_valid_w2", out_valid2, m_valid);
        chk("xfer_count", xfer_count, m_cnt % 256);
        chk("xfer_count_w2", xfer_count2, m_cnt % 4);
        if (m_valid) begin
            chk("sb_Mux_Out", Mux_Out, sbq[0].d);
            chk("sb_out_src", out_src, sbq[0].s);
            chk("sb_Mux_Out_w2", Mux_Out2, sbq[0].d);
        end else if (rst) begin
            chk("rst_Mux_Out", Mux_Out, 0);
            chk("rst_out_src", out_src, 0);
        end
    endtask
    initial begin
        vt[0] = '{MODE_A,    4'b1010, 6'b000000, 1'b0, 6'b001010, 1'b0};
        vt[1] = '{MODE_A,    4'b1010, 6'b000000, 1'b1, 6'b111010, 1'b0};
        vt[2] = '{MODE_A,    4'b0111, 6'b000000, 1'b1, 6'b000111, 1'b0};
        vt[3] = '{MODE_B,    4'b1111, 6'b101101, 1'b1, 6'b101101, 1'b1};
        vt[4] = '{MODE_HOLD, 4'b0101, 6'b000011, 1'b1, 6'b000011, 1'b1};
        vt[5] = '{MODE_ALT,  4'b0001, 6'b100000, 1'b0, 6'b000001, 1'b0};
        vt[6] = '{MODE_ALT,  4'b0001, 6'b100000, 1'b0, 6'b100000, 1'b1};
        vt[7] = '{MODE_ALT,  4'b0001, 6'b100000, 1'b0, 6'b000001, 1'b0};
        vt[8] = '{MODE_ALT,  4'b0001, 6'b100000, 1'b0, 6'b100000, 1'b1};
        @(negedge clk);
        Reset = 1'b1;
        in_valid = 1'b1;
        A = 4'b1111;
        B = 6'b111111;
        cyc();
        cyc();
        chk("reset_count", xfer_count, 0);
        chk("reset_out_valid", out_valid, 0);
        Reset = 1'b0;
        in_valid = 1'b0;
        #1 chk("post_reset_in_ready", in_ready, 1);
        for (int i = 0; i < 9; i++) begin
            mode = vt[i].mode;
            A = vt[i].a;
            B = vt[i].b;
            ext_signed = vt[i].ext;
            in_valid = 1'b1;
            out_ready = 1'b1;
            #1 chk("vec_in_ready", in_ready, 1);
            cyc();
            chk("vec_Mux_Out", Mux_Out, vt[i].d);
            chk("vec_out_src", out_src, vt[i].s);
        end
        in_valid = 1'b0;
        cyc();
        chk("vec_count", xfer_count, 9);
        mode = MODE_ALT;
        A = 4'b0011;
        ext_signed = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        cyc();
        chk("bp_load", Mux_Out, 6'b000011);
        for (int k = 0; k < 3; k++) begin
            A = 4'b0100 + 4'(k);
            #1 chk("bp_in_ready", in_ready, 0);
            cyc();
            chk("bp_hold", Mux_Out, 6'b000011);
            chk("bp_count", xfer_count, 9);
        end
        A = 4'b0111;
        out_ready = 1'b1;
        cyc();
        chk("bp_release_data", Mux_Out, 6'b100000);
        chk("bp_release_src", out_src, 1);
        chk("bp_release_count", xfer_count, 10);
        in_valid = 1'b0;
        cyc();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        mode = MODE_A;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = k < 5;
            A = 4'(k);
            cyc();
            chk("wrap_count", xfer_count2, wexp[k]);
        end
        in_valid = 1'b1;
        mode = MODE_B;
        B = 6'b010101;
        out_ready = 1'b0;
        cyc();
        chk("pend_valid", out_valid, 1);
        Reset = 1'b1;
        cyc();
        chk("drop_valid", out_valid, 0);
        chk("drop_count", xfer_count, 0);
        chk("drop_count_w2", xfer_count2, 0);
        Reset = 1'b0;
        mode = MODE_ALT;
        A = 4'b1001;
        ext_signed = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("post_reset_alt_src", out_src, 0);
        chk("post_reset_alt_data", Mux_Out, 6'b111001);
        in_valid = 1'b0;
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
